pipeline_trace_buffer: RTL and testbench

Synthesizable on-chip trace buffer for the 3-stage MIPS pipeline; it replaces ad-hoc `$monitor` observation of PC and write-back traffic with a parametrised circular capture memory. Sits beside `TopLevel`, samples PC, write-back result and the WB/MEM enable strobes every unfrozen cycle, stops a programmable number of samples after a PC-match trigger, then streams the captured history out oldest-first. An optional compile-time mode holds the pipeline frozen until the trace has been drained.

---
 rtl/pipeline_trace_buffer.sv | 162 ++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
//   Circular capture memory for the 3-stage MIPS pipeline. Samples
//   {mem_w_en, mem_r_en, wb_en, wb_res, pc} on every unfrozen cycle while
//   armed. It stops POST_TRIG samples after a PC-match trigger, then streams
//   the captured history out oldest-first.
//
//   Optional feature macro: TRACE_FREEZE_EN
//     When defined, freeze_req is registered and is high from DONE entry
//     until the final pop. When undefined, freeze_req is tied low.
//
//   Ports
//     clk, rst         clock, asynchronous active-low reset
//     arm              one-cycle pulse: clear buffer and start capturing
//     trig_pc          PC value that fires the trigger
//     freeze_in        pipeline freeze; suppresses capture and trigger
//     pc_in, wb_res_in, wb_en_in, mem_r_en_in, mem_w_en_in   sampled traffic
//     rd_req           pop one entry (DONE only)
//     rd_data/rd_valid registered pop result
//     rd_empty         no unread entries
//     state, done      IDLE=0 ARMED=1 POST=2 DONE=3; done = (state == DONE)
//     freeze_req       pipeline hold request
module pipeline_trace_buffer #(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic [WORD_LEN-1:0]     trig_pc,
  input  logic                    freeze_in,
  input  logic [WORD_LEN-1:0]     pc_in,
  input  logic [WORD_LEN-1:0]     wb_res_in,
  input  logic                    wb_en_in,
  input  logic                    mem_r_en_in,
  input  logic                    mem_w_en_in,
  input  logic                    rd_req,
  output logic [2*WORD_LEN+2:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_empty,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    freeze_req
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned DW  = 2*WORD_LEN+3;
  localparam int unsigned PCW = (POST_TRIG > 1) ? $clog2(POST_TRIG) : 1;
  localparam logic [PCW-1:0] POST_LAST = PCW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);
  localparam logic [AW:0]    FULL      = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [PCW-1:0]  post_cnt_q, post_cnt_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            capture;
  logic [DW-1:0]   sample;
  logic [AW-1:0]   rd_idx;
  logic [DW-1:0]   mem [DEPTH];

  assign sample = {mem_w_en_in, mem_r_en_in, wb_en_in, wb_res_in, pc_in};

  // The oldest unread entry always sits count entries behind the write
  // pointer. Because pops only shrink count, no separate read pointer is
  // needed. A full buffer (count == DEPTH) aliases to wr_ptr itself.
  assign rd_idx = wr_ptr_q - count_q[AW-1:0];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    capture    = 1'b0;
    if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          if (!freeze_in) begin
            capture  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != FULL) count_d = count_q + (AW+1)'(1);
            if (state_q == S_ARMED) begin
              if (pc_in == trig_pc) state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
            end else if (post_cnt_q == POST_LAST) begin
              state_d = S_DONE;
            end else begin
              post_cnt_d = post_cnt_q + PCW'(1);
            end
          end
        end
        S_DONE: begin
          if (rd_req && count_q != '0) begin
            rd_data_d  = mem[rd_idx];
            rd_valid_d = 1'b1;
            count_d    = count_q - (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr_q] <= sample;
  end

`ifdef TRACE_FREEZE_EN
  logic freeze_q, freeze_d;

  // High while DONE still holds unread entries; drops on the emptying pop or on arm.
  assign freeze_d = (state_d == S_DONE) && (count_d != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) freeze_q <= 1'b0;
    else      freeze_q <= freeze_d;
  end

  assign freeze_req = freeze_q;
`else
  assign freeze_req = 1'b0;
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_empty = (count_q == '0);
  assign state    = state_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
module tb_pipeline_trace_buffer;

  localparam int unsigned WL = 32;
  localparam int unsigned DW = 2*WL+3;
`ifdef TRACE_FREEZE_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, arm, freeze_in, wb_en_in, mem_r_en_in, mem_w_en_in, rd_req;
  logic [WL-1:0] trig_pc, pc_in, wb_res_in;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_empty, done, freeze_req;
  logic [1:0]    state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  pipeline_trace_buffer #(.WORD_LEN(WL), .DEPTH(8), .POST_TRIG(2)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_pc(trig_pc), .freeze_in(freeze_in),
    .pc_in(pc_in), .wb_res_in(wb_res_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .state(state), .done(done), .freeze_req(freeze_req)
  );

  always #5 clk = ~clk;

  // Expected sample for a given PC: side fields are derived from the PC.
  function automatic logic [DW-1:0] mk(input logic [WL-1:0] pc);
    logic [WL-1:0] wb;
    wb = pc * 32'd3 + 32'h1000;
    return {pc[4], pc[3], pc[2], wb, pc};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented read result is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %0h expected no output", rd_data);
      end else begin
        chk("rd_data", 128'(rd_data), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WL-1:0] pc, input logic frz);
    logic [DW-1:0] s;
    s = mk(pc);
    pc_in       = pc;
    wb_res_in   = s[2*WL-1:WL];
    wb_en_in    = s[DW-3];
    mem_r_en_in = s[DW-2];
    mem_w_en_in = s[DW-1];
    freeze_in   = frz;
    step();
  endtask

  task automatic pop(input logic [WL-1:0] pc);
    rd_req = 1'b1;
    exp_q.push_back(mk(pc));
    step();
  endtask

  task automatic do_arm(input logic [WL-1:0] tpc);
    trig_pc   = tpc;
    freeze_in = 1'b0;
    arm       = 1'b1;
    step();
    arm       = 1'b0;
    chk("armed_state", 128'(state), 128'(1));
    chk("armed_freeze_req", 128'(freeze_req), 128'(0));
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0; freeze_in = 1'b0; rd_req = 1'b0;
    trig_pc = '0; pc_in = '0; wb_res_in = '0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_empty", 128'(rd_empty), 128'(1));
    chk("rst_freeze_req", 128'(freeze_req), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));
    rst = 1'b1;
    step();

    // Wrap + trigger: 13 samples into 8 entries, trigger at 0x28.
    do_arm(32'h28);
    for (int i = 0; i < 13; i++) begin
      drive(WL'(i * 4), 1'b0);
      if (i == 10) chk("wrap_post_state", 128'(state), 128'(2));
    end
    chk("wrap_done_state", 128'(state), 128'(3));
    chk("wrap_done", 128'(done), 128'(1));
    chk("wrap_freeze_on", 128'(freeze_req), 128'(FE));
    chk("wrap_not_empty", 128'(rd_empty), 128'(0));
    for (int i = 0; i < 8; i++) begin
      pop(WL'(32'h14 + i * 4));
      chk("wrap_rd_valid", 128'(rd_valid), 128'(1));
      chk("wrap_rd_empty", 128'(rd_empty), 128'(i == 7));
      chk("wrap_freeze", 128'(freeze_req), 128'((i == 7) ? 1'b0 : FE));
    end
    rd_req = 1'b0;
    step();
    chk("wrap_valid_drop", 128'(rd_valid), 128'(0));

    // Early trigger on the very first sample.
    do_arm(32'h00);
    drive(32'h00, 1'b0);
    drive(32'h04, 1'b0);
    drive(32'h08, 1'b0);
    chk("early_done_state", 128'(state), 128'(3));
    pop(32'h00);
    pop(32'h04);
    pop(32'h08);
    chk("early_empty", 128'(rd_empty), 128'(1));
    step();
    chk("early_pop_empty_valid", 128'(rd_valid), 128'(0));
    rd_req = 1'b0;

    // Freeze suppresses both trigger and capture.
    do_arm(32'h28);
    drive(32'h20, 1'b0);
    drive(32'h24, 1'b0);
    drive(32'h28, 1'b1);
    chk("frz_no_trigger", 128'(state), 128'(1));
    drive(32'h28, 1'b0);
    chk("frz_trigger", 128'(state), 128'(2));
    drive(32'h2C, 1'b1);
    drive(32'h30, 1'b1);
    chk("frz_post_hold", 128'(state), 128'(2));
    drive(32'h34, 1'b0);
    chk("frz_post_one", 128'(state), 128'(2));
    drive(32'h38, 1'b0);
    chk("frz_done", 128'(state), 128'(3));
    pop(32'h20);
    pop(32'h24);
    pop(32'h28);
    pop(32'h34);
    pop(32'h38);
    rd_req = 1'b0;
    chk("frz_empty", 128'(rd_empty), 128'(1));
    chk("frz_freeze_off", 128'(freeze_req), 128'(0));

    // Asynchronous reset between pops.
    do_arm(32'h00);
    drive(32'h00, 1'b0);
    drive(32'h04, 1'b0);
    drive(32'h08, 1'b0);
    pop(32'h00);
    rd_req = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_state", 128'(state), 128'(0));
    chk("async_rd_valid", 128'(rd_valid), 128'(0));
    chk("async_done", 128'(done), 128'(0));
    chk("async_rd_empty", 128'(rd_empty), 128'(1));
    chk("async_freeze_req", 128'(freeze_req), 128'(0));
    step();
    rst = 1'b1;
    step();

    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
